fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited request issue, 2-entry in-order queue to decode, redirect
// with in-flight discard. Optional macro FETCH_MISALIGN_CHECK_EN enables misaligned-redirect faults.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instruct,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        misalign_fault
);

  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  out_cnt_q, out_cnt_d;
  logic [1:0]  disc_q, disc_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        fault_q, fault_d;
  logic [31:0] q_inst_q [2];
  logic [31:0] q_pc_q [2];

  logic [31:0] redir_target;
  logic        redir_bad;
  logic        accept;
  logic        rsp_live;
  logic        rsp_keep;
  logic        deq;
  logic [31:0] rsp_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redir_target = redirect_pc;
  assign redir_bad    = (redirect_pc[1:0] != 2'b00);
`else
  logic unused_redir_lsb;
  assign unused_redir_lsb = ^redirect_pc[1:0];
  assign redir_target     = {redirect_pc[31:2], 2'b00};
  assign redir_bad        = 1'b0;
`endif

  // Queue slots plus in-flight requests never exceed two, so the queue cannot overflow.
  assign imem_req_valid = rst_n && !redirect_valid && !fault_q &&
                          (({1'b0, cnt_q} + {1'b0, out_cnt_q}) < 3'd2);
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign rsp_live = imem_rsp_valid && (out_cnt_q != 2'd0);
  assign rsp_keep = rsp_live && (disc_q == 2'd0) && !redirect_valid;
  // Kept requests are contiguous and end just below pc_q, so the oldest sits out_cnt words back.
  assign rsp_pc   = pc_q - {28'd0, out_cnt_q, 2'b00};

  assign id_valid       = (cnt_q != 2'd0) && !redirect_valid;
  assign deq            = id_valid && id_ready;
  assign id_instruct    = (cnt_q != 2'd0) ? q_inst_q[rd_ptr_q] : NOP_INST;
  assign id_pc          = (cnt_q != 2'd0) ? q_pc_q[rd_ptr_q] : pc_q;
  assign id_pc4         = id_pc + 32'd4;
  assign misalign_fault = fault_q;

  always_comb begin
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    out_cnt_d = out_cnt_q + {1'b0, accept} - {1'b0, rsp_live};
    disc_d    = disc_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    fault_d   = fault_q;
    if (redirect_valid) begin
      pc_d     = redir_target;
      cnt_d    = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      // Everything still in flight after this cycle belongs to the abandoned path.
      disc_d   = out_cnt_q - {1'b0, rsp_live};
      fault_d  = redir_bad;
    end else begin
      if (accept) begin
        pc_d = pc_q + 32'd4;
      end
      if (rsp_live && (disc_q != 2'd0)) begin
        disc_d = disc_q - 2'd1;
      end
      cnt_d    = cnt_q + {1'b0, rsp_keep} - {1'b0, deq};
      rd_ptr_d = rd_ptr_q ^ deq;
      wr_ptr_d = wr_ptr_q ^ rsp_keep;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      cnt_q     <= 2'd0;
      out_cnt_q <= 2'd0;
      disc_q    <= 2'd0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      out_cnt_q <= out_cnt_d;
      disc_q    <= disc_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      fault_q   <= fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rsp_keep) begin
      q_inst_q[wr_ptr_q] <= imem_rsp_data;
      q_pc_q[wr_ptr_q]   <= rsp_pc;
    end
  end

endmodule
